dcache_block_reader: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MIPS datapath's load/store stage and the 16-byte-block data memory. Load hits return a 32-bit word combinationally. A load miss stalls the pipeline, holds a block-aligned address on the memory port for a fixed latency, then captures the 128-bit block into the line array. Stores pass straight through to the memory's 32-bit write port and update the cached word on a hit.

---
 rtl/dcache_block_reader.sv | 120 ++++++++++++
 tb/tb_dcache_block_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_block_reader.sv
// Direct-mapped, write-through, no-write-allocate data cache with 16-byte lines.
// Load misses fetch a whole block after a fixed memory latency; stores always go straight to memory.
module dcache_block_reader #(
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic         CLk,
    input  logic         reset,
    input  logic [31:0]  cpuAddress,
    input  logic         cpuRead,
    input  logic         cpuWrite,
    input  logic [31:0]  cpuWriteData,
    output logic [31:0]  cpuReadData,
    output logic         stall,
    output logic [31:0]  memAddress,
    output logic         memWrite,
    output logic [31:0]  memWriteData,
    output logic         memRead,
    input  logic [127:0] memReadData,
    output logic [15:0]  hitCount,
    output logic [15:0]  missCount
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [27:0]      r_fill_blk;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [127:0]     r_data [LINES];
    logic [15:0]      r_hit_cnt;
    logic [15:0]      r_miss_cnt;

    logic [1:0]       w_word;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_idle;
    logic             w_match;
    logic             w_store;
    logic             w_load;
    logic             w_hit;
    logic             w_miss;
    logic             w_fill_done;
    logic             w_unused;

    assign w_word      = cpuAddress[3:2];
    assign w_idx       = cpuAddress[4 +: IDX_W];
    assign w_tag       = cpuAddress[31 -: TAG_W];
    assign w_fill_idx  = r_fill_blk[0 +: IDX_W];
    assign w_fill_tag  = r_fill_blk[27 -: TAG_W];
    assign w_unused    = &{1'b0, cpuAddress[1:0]};

    // Stores take priority over loads, and nothing is accepted while a fill is in flight.
    assign w_idle      = (r_state == IDLE);
    assign w_match     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_store     = w_idle && cpuWrite;
    assign w_load      = w_idle && cpuRead && !cpuWrite;
    assign w_hit       = w_load && w_match;
    assign w_miss      = w_load && !w_match;
    assign w_fill_done = !w_idle && (r_cnt == CNT_LAST);

    assign stall        = w_miss || !w_idle;
    assign memRead      = !w_idle;
    assign memWrite     = w_store;
    assign memAddress   = w_idle ? cpuAddress : {r_fill_blk, 4'b0000};
    assign memWriteData = cpuWriteData;
    assign cpuReadData  = w_hit ? r_data[w_idx][{w_word, 5'b00000} +: 32] : 32'h0;
    assign hitCount     = r_hit_cnt;
    assign missCount    = r_miss_cnt;

    always_ff @(posedge CLk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_fill_blk <= '0;
            r_valid    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != 16'hFFFF))
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_miss && (r_miss_cnt != 16'hFFFF))
                r_miss_cnt <= r_miss_cnt + 16'd1;
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_state    <= FILL;
                        r_cnt      <= '0;
                        r_fill_blk <= cpuAddress[31:4];
                    end
                end
                FILL: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_fill_done) begin
                        r_state             <= IDLE;
                        r_valid[w_fill_idx] <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether their contents are used.
    always_ff @(posedge CLk) begin
        if (w_fill_done) begin
            r_data[w_fill_idx] <= memReadData;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end else if (w_store && w_match) begin
            r_data[w_idx][{w_word, 5'b00000} +: 32] <= cpuWriteData;
        end
    end
endmodule

// File: tb/tb_dcache_block_reader.sv
// Directed bench for dcache_block_reader: a word-addressed memory model answers block fetches and
// records stores; each scenario task checks stall timing, data and counters against hand-computed values.
module tb_dcache_block_reader;
    logic         CLk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  cpuAddress = '0;
    logic         cpuRead = 1'b0;
    logic         cpuWrite = 1'b0;
    logic [31:0]  cpuWriteData = '0;
    logic [31:0]  cpuReadData;
    logic         stall;
    logic [31:0]  memAddress;
    logic         memWrite;
    logic [31:0]  memWriteData;
    logic         memRead;
    logic [127:0] memReadData = '0;
    logic [15:0]  hitCount;
    logic [15:0]  missCount;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];

    dcache_block_reader #(.LINES(16), .MEM_LATENCY(4)) dut (
        .CLk(CLk), .reset(reset), .cpuAddress(cpuAddress), .cpuRead(cpuRead),
        .cpuWrite(cpuWrite), .cpuWriteData(cpuWriteData), .cpuReadData(cpuReadData),
        .stall(stall), .memAddress(memAddress), .memWrite(memWrite),
        .memWriteData(memWriteData), .memRead(memRead), .memReadData(memReadData),
        .hitCount(hitCount), .missCount(missCount)
    );

    always #5 CLk = ~CLk;

    // Unwritten memory words read as their byte address XOR 0xC0DE0000.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge CLk) begin
        if (memWrite) mem[{memAddress[31:2], 2'b00}] = memWriteData;
    end

    always @(negedge CLk) begin
        logic [31:0] base;
        base = {memAddress[31:4], 4'b0000};
        memReadData = {word_at(base + 32'd12), word_at(base + 32'd8),
                       word_at(base + 32'd4), word_at(base)};
    end

    task automatic apply_reset();
        cpuRead  = 1'b0;
        cpuWrite = 1'b0;
        reset    = 1'b1;
        @(posedge CLk); #1;
        reset = 1'b0;
    endtask

    // Holds a load until stall drops (bounded), reporting stall cycles, fill cycles that carried the
    // right block address, and the returned word; one more edge lets the hit be counted.
    task automatic do_load(input logic [31:0] addr, output int stalls, output int fills,
                           output logic [31:0] data);
        bit done = 0;
        stalls     = 0;
        fills      = 0;
        data       = 'x;
        cpuAddress = addr;
        cpuRead    = 1'b1;
        cpuWrite   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLk);
            if (memRead && memAddress === {addr[31:4], 4'b0000}) fills++;
            if (stall !== 1'b0) begin
                stalls++;
                @(posedge CLk); #1;
            end else begin
                done = 1;
                data = cpuReadData;
            end
        end
        @(posedge CLk); #1;
        cpuRead = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge CLk);
        n_checks++; if ({stall, memRead, memWrite} !== 3'b000) begin n_fail++;
            $display("FAIL reset_ctrl: stall/memRead/memWrite=%b required 000", {stall, memRead, memWrite}); end
        n_checks++; if (cpuReadData !== 32'h0) begin n_fail++;
            $display("FAIL reset_rdata: got %h required 0", cpuReadData); end
        n_checks++; if ({hitCount, missCount} !== 32'h0) begin n_fail++;
            $display("FAIL reset_counts: hit=%h miss=%h required 0/0", hitCount, missCount); end
        @(posedge CLk); #1;
    endtask

    task automatic test_load_miss();
        int s, f; logic [31:0] d;
        apply_reset();
        do_load(32'h40, s, f, d);
        n_checks++; if (s !== 5) begin n_fail++; $display("FAIL miss_stall: got %0d required 5", s); end
        n_checks++; if (f !== 4) begin n_fail++; $display("FAIL miss_fill_addr: got %0d cycles required 4", f); end
        n_checks++; if (d !== 32'hC0DE_0040) begin n_fail++; $display("FAIL miss_data: got %h required c0de0040", d); end
        n_checks++; if (missCount !== 16'd1 || hitCount !== 16'd1) begin n_fail++;
            $display("FAIL miss_counts: hit=%0d miss=%0d required 1/1", hitCount, missCount); end
    endtask

    task automatic test_store_miss();
        int s, f; logic [31:0] d;
        apply_reset();
        cpuAddress = 32'h80; cpuWriteData = 32'hDEAD_BEEF; cpuWrite = 1'b1;
        @(negedge CLk);
        n_checks++; if ({memWrite, stall} !== 2'b10 || memAddress !== 32'h80 || memWriteData !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL store_miss_port: memWrite=%b stall=%b addr=%h data=%h required 1 0 80 deadbeef",
                               memWrite, stall, memAddress, memWriteData); end
        @(posedge CLk); #1;
        cpuWrite = 1'b0;
        do_load(32'h84, s, f, d);
        n_checks++; if (s !== 5 || d !== 32'hC0DE_0084) begin n_fail++;
            $display("FAIL store_no_alloc: stall=%0d data=%h required 5 c0de0084", s, d); end
        do_load(32'h80, s, f, d);
        n_checks++; if (s !== 0 || d !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL store_mem_data: stall=%0d data=%h required 0 deadbeef", s, d); end
        n_checks++; if (missCount !== 16'd1 || hitCount !== 16'd2) begin n_fail++;
            $display("FAIL store_miss_counts: hit=%0d miss=%0d required 2/1", hitCount, missCount); end
    endtask

    task automatic test_store_hit();
        int s, f; logic [31:0] d;
        apply_reset();
        do_load(32'h40, s, f, d);
        cpuAddress = 32'h44; cpuWriteData = 32'h1234_5678; cpuWrite = 1'b1;
        @(negedge CLk);
        n_checks++; if ({memWrite, stall} !== 2'b10 || memAddress !== 32'h44) begin n_fail++;
            $display("FAIL store_hit_port: memWrite=%b stall=%b addr=%h required 1 0 44", memWrite, stall, memAddress); end
        @(posedge CLk); #1;
        cpuWrite = 1'b0;
        do_load(32'h44, s, f, d);
        n_checks++; if (s !== 0 || d !== 32'h1234_5678) begin n_fail++;
            $display("FAIL store_hit_update: stall=%0d data=%h required 0 12345678", s, d); end
        n_checks++; if (missCount !== 16'd1 || hitCount !== 16'd2) begin n_fail++;
            $display("FAIL store_hit_counts: hit=%0d miss=%0d required 2/1", hitCount, missCount); end
    endtask

    task automatic test_conflict();
        int s0, s1, s2, f; logic [31:0] d0, d1, d2;
        apply_reset();
        do_load(32'h40, s0, f, d0);
        do_load(32'h140, s1, f, d1);
        do_load(32'h40, s2, f, d2);
        n_checks++; if (s0 !== 5 || s1 !== 5 || s2 !== 5) begin n_fail++;
            $display("FAIL conflict_stalls: got %0d %0d %0d required 5 5 5", s0, s1, s2); end
        n_checks++; if (d1 !== 32'hC0DE_0140 || d2 !== 32'hC0DE_0040) begin n_fail++;
            $display("FAIL conflict_data: got %h %h required c0de0140 c0de0040", d1, d2); end
        n_checks++; if (missCount !== 16'd3) begin n_fail++;
            $display("FAIL conflict_misses: got %0d required 3", missCount); end
    endtask

    task automatic test_addr_hold();
        int s, f; logic [31:0] d;
        apply_reset();
        cpuAddress = 32'h300; cpuRead = 1'b1;
        @(posedge CLk); #1;
        cpuAddress = 32'h7F0;
        @(negedge CLk);
        n_checks++; if (memRead !== 1'b1 || memAddress !== 32'h300) begin n_fail++;
            $display("FAIL fill_addr_hold: memRead=%b addr=%h required 1 300", memRead, memAddress); end
        @(posedge CLk); #1;
        do_load(32'h300, s, f, d);
        n_checks++; if (s !== 3 || d !== 32'hC0DE_0300) begin n_fail++;
            $display("FAIL fill_addr_result: stall=%0d data=%h required 3 c0de0300", s, d); end
    endtask

    task automatic test_reset_mid_fill();
        int s, f; logic [31:0] d;
        apply_reset();
        cpuAddress = 32'h200; cpuRead = 1'b1;
        repeat (3) begin @(posedge CLk); #1; end
        n_checks++; if (memRead !== 1'b1 || stall !== 1'b1) begin n_fail++;
            $display("FAIL abort_pre: memRead=%b stall=%b required 1 1", memRead, stall); end
        cpuRead = 1'b0;
        reset   = 1'b1;
        #1;
        n_checks++; if (memRead !== 1'b0 || stall !== 1'b0) begin n_fail++;
            $display("FAIL abort_drop: memRead=%b stall=%b required 0 0", memRead, stall); end
        @(posedge CLk); #1;
        reset = 1'b0;
        do_load(32'h200, s, f, d);
        n_checks++; if (s !== 5 || d !== 32'hC0DE_0200) begin n_fail++;
            $display("FAIL abort_refetch: stall=%0d data=%h required 5 c0de0200", s, d); end
    endtask

    task automatic test_saturation();
        int s, f; logic [31:0] d;
        apply_reset();
        do_load(32'h40, s, f, d);
        cpuAddress = 32'h40; cpuRead = 1'b1;
        repeat (65533) @(posedge CLk);
        @(negedge CLk);
        n_checks++; if (hitCount !== 16'hFFFE) begin n_fail++;
            $display("FAIL sat_before: hit=%h required fffe", hitCount); end
        @(posedge CLk);
        @(negedge CLk);
        n_checks++; if (hitCount !== 16'hFFFF) begin n_fail++;
            $display("FAIL sat_reach: hit=%h required ffff", hitCount); end
        repeat (5) @(posedge CLk);
        @(negedge CLk);
        n_checks++; if (hitCount !== 16'hFFFF || missCount !== 16'd1 || stall !== 1'b0) begin n_fail++;
            $display("FAIL sat_hold: hit=%h miss=%0d stall=%b required ffff 1 0", hitCount, missCount, stall); end
        cpuRead = 1'b0;
        @(posedge CLk); #1;
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_store_miss();
        test_store_hit();
        test_conflict();
        test_addr_hold();
        test_reset_mid_fill();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
